switch_control: RTL
===================

// Module: switch_control
// PURPOSE
//  Central switch allocator of one Phoenix router. It arbitrates routing requests from the
//  NPORT input fifo_buffers in round-robin order and computes the XY route from each header flit.
//  It allocates a free output port and drives the crossbar selects.
//  Each connection is held until the input side finishes sending its packet.
// PARAMETERS
//  NPORT      5          number of router ports (EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4)
//  WIDTH      `TAM_FLIT  flit width; header target addr = WIDTH/2 LSBs, X in upper half, Y in lower
//  ROUTER_XY  0          this router's address, WIDTH/2 bits, same X/Y split as header
// PORTS
//  clock    in   1          rising-edge clock
//  reset    in   1          asynchronous, active-high reset
//  h        in   NPORT      h[i]=1: input i has a header flit at its buffer head, requests routing
//  data     in   NPORT*WIDTH  head flit of input i at data[i*WIDTH +: WIDTH]
//  sender   in   NPORT      sender[i]=1 while input i is transmitting its connected packet
//  ack_h    out  NPORT      one-cycle grant pulse to input i; connection established
//  free     out  NPORT      free[o]=1: output port o unallocated
//  mux_in   out  NPORT*3    output port driven by input i; 3'b111 = none
//  mux_out  out  NPORT*3    input feeding output o; 3'b111 = none
// BEHAVIOUR
//  Reset (async, any time, incl. mid-grant): state=IDLE, rr pointer=NPORT-1, ack_h=0, free=all 1,
//    every mux_in/mux_out field=3'b111, sender history=0. All outputs are registered.
//  FSM, one transition per clock:
//    IDLE  : if |h -> SEL, else stay.
//    SEL   : sel = first i with h[i]=1 searching ptr+1, ptr+2, ... mod NPORT; ptr<=sel -> ROUTE.
//            If h dropped to all-zero meanwhile -> IDLE.
//    ROUTE : tx,ty from data[sel]; lx,ly from ROUTER_XY; unsigned compare.
//            Direction: tx>lx EAST; tx<lx WEST; else ty>ly NORTH; ty<ly SOUTH; else LOCAL.
//            Result is registered as dir -> GRANT.
//    GRANT : if free[dir] && h[sel], then on the next edge free[dir]<=0, mux_in[sel]<=dir,
//              mux_out[dir]<=sel, ack_h[sel]<=1.
//            Otherwise no change (blocked). Both cases -> IDLE.
//  ack_h is high exactly one cycle, with the FSM in IDLE. Min latency: h rises in IDLE at edge
//    n, ack_h visible after edge n+4.
//  A blocked request is not queued. ptr has already advanced past it, so other inputs are served
//    first; the input retries by keeping h high.
//  Release: registered copy sender_q; falling edge (sender_q[i]=1, sender[i]=0) with
//    mux_in[i]!=7:
//    on that edge, free[mux_in[i]]<=1, mux_out[that port]<=7, mux_in[i]<=7.
//    Several releases may occur on one edge; all apply.
//  Release and grant on the same edge: both apply.
//    A port released on edge k is only seen free by GRANT in a later cycle.
//    No same-cycle bypass of a release.
//  U-turn is not allowed (dir==sel for non-LOCAL): treated as blocked, no ack.
//    A local-to-local route is legal.
//  h[i] while input i is already connected (mux_in[i]!=7) is ignored by SEL.
// TESTING
//  1. ROUTER_XY=8'h11, reset, h=5'b10000, data[LOCAL]=8'h21 (tx=2>1).
//     -> ack_h[4] 4 cycles later, free[0]=0, mux_out[0]=4, mux_in[4]=0.
//  2. Round robin: h=5'b00011, targets on distinct ports.
//     -> EAST input granted first, WEST next.
//     -> with ptr=0 and h=5'b00011 again, WEST (1) wins before EAST.
//  3. Contention: inputs 0 and 4 both target NORTH (data=8'h12).
//     -> one ack, the other blocked with no ack until sender of the winner falls.
//     -> then free[2]=1 and the blocked input is granted.
//  4. Release+grant same edge: sender[1] falls on the GRANT edge for another port.
//     -> both mux updates land, free reflects both.
//  5. Async reset asserted in ROUTE with 3 connections live.
//     -> immediately free=5'b11111, all mux fields 3'b111, ack_h=0, FSM IDLE.
//  6. Header 8'h11 at router 8'h11 -> LOCAL.
//     Header 8'h10 -> SOUTH, 8'h01 -> WEST, 8'h1F -> NORTH.

Source files
------------

// File: rtl/switch_control_if.sv
// Allocator-side bundle of one Phoenix router: header requests and flits in,
// grants, free flags and crossbar selects out.
interface switch_control_if #(
    parameter int NPORT = 5,
    parameter int WIDTH = 16
);
    logic [NPORT-1:0]       h;
    logic [NPORT*WIDTH-1:0] data;
    logic [NPORT-1:0]       sender;
    logic [NPORT-1:0]       ack_h;
    logic [NPORT-1:0]       free;
    logic [NPORT*3-1:0]     mux_in;
    logic [NPORT*3-1:0]     mux_out;

    modport master (output h, data, sender, input ack_h, free, mux_in, mux_out);
    modport slave  (input h, data, sender, output ack_h, free, mux_in, mux_out);
endinterface

// File: rtl/switch_control.sv
// Phoenix router switch allocator: round-robin header arbitration, XY routing,
// output-port allocation and release of the crossbar connections.
module switch_control #(
    parameter int NPORT = 5,
    parameter int WIDTH = 16,
    parameter logic [WIDTH/2-1:0] ROUTER_XY = '0
) (
    input logic clock,
    input logic reset,
    switch_control_if.slave sw
);
    localparam int unsigned NP = NPORT;
    localparam int HW = WIDTH / 2;
    localparam int QW = WIDTH / 4;
    localparam logic [2:0] EAST  = 3'd0;
    localparam logic [2:0] WEST  = 3'd1;
    localparam logic [2:0] NORTH = 3'd2;
    localparam logic [2:0] SOUTH = 3'd3;
    localparam logic [2:0] LOCAL = 3'd4;
    localparam logic [2:0] NONE  = 3'b111;

    typedef enum logic [1:0] {IDLE, SEL, ROUTE, GRANT} state_t;

    state_t state_q, state_d;
    logic [2:0] ptr_q, ptr_d, sel_q, sel_d, dir_q, dir_d;
    logic [NPORT-1:0] ack_q, ack_d, free_q, free_d, sender_q;
    logic [NPORT-1:0][2:0] mux_in_q, mux_in_d, mux_out_q, mux_out_d;

    logic [NPORT-1:0] req;
    logic found;
    logic [2:0] pick;
    logic [HW-1:0] addr;
    logic [QW-1:0] tx, ty, lx, ly;
    logic grant_ok;

    // Inputs already holding a connection are not eligible for arbitration.
    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < NP; i++)
            req[i] = sw.h[i] && (mux_in_q[i] == NONE);
    end

    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int unsigned k = 1; k <= NP; k++) begin
            if (!found && req[(32'(ptr_q) + k) % NP]) begin
                found = 1'b1;
                pick  = 3'((32'(ptr_q) + k) % NP);
            end
        end
    end

    always_comb begin
        addr = sw.data[int'(sel_q) * WIDTH +: HW];
        tx   = addr[HW-1:QW];
        ty   = addr[QW-1:0];
        lx   = ROUTER_XY[HW-1:QW];
        ly   = ROUTER_XY[QW-1:0];
        grant_ok = free_q[dir_q] && sw.h[sel_q] && ((dir_q != sel_q) || (dir_q == LOCAL));
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        dir_d     = dir_q;
        ack_d     = '0;
        free_d    = free_q;
        mux_in_d  = mux_in_q;
        mux_out_d = mux_out_q;

        // Releases are applied first; a grant never touches a port or input being released.
        for (int unsigned i = 0; i < NP; i++) begin
            if (sender_q[i] && !sw.sender[i] && (mux_in_q[i] != NONE)) begin
                free_d[mux_in_q[i]]    = 1'b1;
                mux_out_d[mux_in_q[i]] = NONE;
                mux_in_d[i]            = NONE;
            end
        end

        unique case (state_q)
            IDLE: if (|sw.h) state_d = SEL;
            SEL: begin
                if (found) begin
                    sel_d   = pick;
                    ptr_d   = pick;
                    state_d = ROUTE;
                end else begin
                    state_d = IDLE;
                end
            end
            ROUTE: begin
                if (tx > lx)      dir_d = EAST;
                else if (tx < lx) dir_d = WEST;
                else if (ty > ly) dir_d = NORTH;
                else if (ty < ly) dir_d = SOUTH;
                else              dir_d = LOCAL;
                state_d = GRANT;
            end
            GRANT: begin
                if (grant_ok) begin
                    free_d[dir_q]    = 1'b0;
                    mux_in_d[sel_q]  = dir_q;
                    mux_out_d[dir_q] = sel_q;
                    ack_d[sel_q]     = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= 3'(NPORT - 1);
            sel_q     <= '0;
            dir_q     <= '0;
            ack_q     <= '0;
            free_q    <= '1;
            mux_in_q  <= '1;
            mux_out_q <= '1;
            sender_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            dir_q     <= dir_d;
            ack_q     <= ack_d;
            free_q    <= free_d;
            mux_in_q  <= mux_in_d;
            mux_out_q <= mux_out_d;
            sender_q  <= sw.sender;
        end
    end

    assign sw.ack_h   = ack_q;
    assign sw.free    = free_q;
    assign sw.mux_in  = mux_in_q;
    assign sw.mux_out = mux_out_q;
endmodule
